// File: rtl/multi_timer.sv
// Register-mapped bank of N_CH down-counting timers with per-channel prescaler,
// one-shot / auto-reload / free-run modes and maskable sticky interrupts.
module multi_timer #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int PRE_W = 8
) (
  input  logic                       clk_in,
  input  logic                       sys_rstn,
  input  logic [$clog2(N_CH)+1:0]    addr,
  input  logic                       we,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata,
  output logic [N_CH-1:0]            irq,
  output logic                       irq_any
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int AW   = $clog2(N_CH) + 2;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic [CH_W-1:0] ch_sel;
  logic [1:0]      reg_sel;

  assign reg_sel = addr[1:0];

  if (N_CH == 1) begin : g_one_ch
    assign ch_sel = '0;
  end else begin : g_multi_ch
    assign ch_sel = addr[AW-1:2];
  end

  logic [N_CH-1:0]            en_v;
  logic [N_CH-1:0]            im_v;
  logic [N_CH-1:0]            pend_v;
  logic [N_CH-1:0][1:0]       mode_v;
  logic [N_CH-1:0][PRE_W-1:0] pre_v;
  logic [N_CH-1:0][CNT_W-1:0] preset_v;
  logic [N_CH-1:0][CNT_W-1:0] count_v;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             sel;
    logic             ctrl_wr;
    logic             preset_wr;
    logic             status_wr;
    logic             en;
    logic [1:0]       mode;
    logic             im;
    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] psc;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic             pend;
    logic             tick;
    logic             upd;
    logic             free;
    logic             expire;
    logic             hw_dis;

    assign sel       = we && (ch_sel == CH_W'(i));
    assign ctrl_wr   = sel && (reg_sel == REG_CTRL);
    assign preset_wr = sel && (reg_sel == REG_PRESET);
    assign status_wr = sel && (reg_sel == REG_STATUS);

    // A CPU write to CTRL/PRESET on a tick edge swallows that tick entirely.
    always_comb begin
      tick   = en && (psc == pre);
      upd    = tick && !ctrl_wr && !preset_wr;
      free   = (mode == 2'b10);
      expire = upd && (free ? (count == '0) : (count == CNT_W'(1)));
      hw_dis = upd && !free &&
               ((count == '0) || ((count == CNT_W'(1)) && (mode != 2'b01)));
    end

    always_ff @(posedge clk_in or negedge sys_rstn) begin
      if (!sys_rstn) begin
        en     <= 1'b0;
        mode   <= 2'b00;
        im     <= 1'b0;
        pre    <= '0;
        psc    <= '0;
        preset <= '0;
        count  <= '0;
        pend   <= 1'b0;
      end else begin
        if (ctrl_wr || preset_wr || !en || tick)
          psc <= '0;
        else
          psc <= psc + 1'b1;

        if (ctrl_wr) begin
          en   <= wdata[0];
          mode <= wdata[2:1];
          im   <= wdata[3];
          pre  <= wdata[8 +: PRE_W];
        end else if (hw_dis) begin
          en <= 1'b0;
        end

        if (preset_wr) begin
          preset <= wdata[CNT_W-1:0];
          count  <= wdata[CNT_W-1:0];
        end else if (upd) begin
          if (free || (count > CNT_W'(1)))
            count <= count - 1'b1;
          else if (count == CNT_W'(1))
            count <= (mode == 2'b01) ? preset : '0;
        end

        // Hardware set beats a simultaneous write-1-to-clear.
        if (expire)
          pend <= 1'b1;
        else if (status_wr && wdata[0])
          pend <= 1'b0;
      end
    end

    assign en_v[i]     = en;
    assign im_v[i]     = im;
    assign pend_v[i]   = pend;
    assign mode_v[i]   = mode;
    assign pre_v[i]    = pre;
    assign preset_v[i] = preset;
    assign count_v[i]  = count;
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL: begin
        rdata[0]          = en_v[ch_sel];
        rdata[2:1]        = mode_v[ch_sel];
        rdata[3]          = im_v[ch_sel];
        rdata[8 +: PRE_W] = pre_v[ch_sel];
      end
      REG_PRESET: rdata = 32'(preset_v[ch_sel]);
      REG_COUNT:  rdata = 32'(count_v[ch_sel]);
      REG_STATUS: rdata[0] = pend_v[ch_sel];
      default:    rdata = '0;
    endcase
  end

  assign irq     = pend_v & im_v;
  assign irq_any = |irq;

  logic unused_wdata;
  assign unused_wdata = ^wdata;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer (N_CH=4, CNT_W=8): reads are queued with
// hand-computed expectations and compared by a decoupled negedge monitor.
module tb_multi_timer;

  logic        clk_in;
  logic        sys_rstn;
  logic [3:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  irq;
  logic        irq_any;
  logic        rd_req;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic [4:0]  irqx;
  } exp_t;

  exp_t q[$];
  int   n_chk;
  int   n_fail;

  multi_timer #(.N_CH(4), .CNT_W(8), .PRE_W(8)) dut (
    .clk_in  (clk_in),
    .sys_rstn(sys_rstn),
    .addr    (addr),
    .we      (we),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq),
    .irq_any (irq_any)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [3:0] a(input int ch, input int r);
    return 4'(ch * 4 + r);
  endfunction

  task automatic wr(input logic [3:0] ad, input logic [31:0] d);
    addr  = ad;
    wdata = d;
    we    = 1'b1;
    @(posedge clk_in);
    #1;
    we = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [3:0] ad, input logic [31:0] er,
                     input logic [3:0] ei);
    exp_t e;
    e.name = nm;
    e.rd   = er;
    e.irqx = {|ei, ei};
    q.push_back(e);
    addr   = ad;
    rd_req = 1'b1;
    @(negedge clk_in);
    #1;
    rd_req = 1'b0;
  endtask

  always @(negedge clk_in) begin
    if (rd_req) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_underflow: read presented with no expectation queued");
      end else begin
        exp_t e;
        e = q.pop_front();
        n_chk++;
        if (rdata !== e.rd) begin
          n_fail++;
          $display("FAIL %s rdata: got %h want %h", e.name, rdata, e.rd);
        end
        n_chk++;
        if ({irq_any, irq} !== e.irqx) begin
          n_fail++;
          $display("FAIL %s irq_any/irq: got %b want %b", e.name, {irq_any, irq}, e.irqx);
        end
      end
    end
  end

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    sys_rstn = 1'b0;
    we       = 1'b0;
    rd_req   = 1'b0;
    addr     = '0;
    wdata    = '0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_ctrl0",   a(0, 0), 32'h0, 4'b0000);
    chk("rst_preset1", a(1, 1), 32'h0, 4'b0000);
    #2 sys_rstn = 1'b1;
    chk("rst_count2",  a(2, 2), 32'h0, 4'b0000);
    chk("rst_status3", a(3, 3), 32'h0, 4'b0000);

    // one-shot, PRESET=3, PRE=0
    wr(a(0, 1), 32'd3);
    wr(a(0, 0), 32'h9);
    chk("os_cnt_e1",   a(0, 2), 32'd3, 4'b0000);
    chk("os_cnt_e2",   a(0, 2), 32'd2, 4'b0000);
    chk("os_cnt_e3",   a(0, 2), 32'd1, 4'b0000);
    chk("os_expire",   a(0, 2), 32'd0, 4'b0001);
    chk("os_en_clr",   a(0, 0), 32'h8, 4'b0001);
    chk("os_pend",     a(0, 3), 32'h1, 4'b0001);
    wr(a(0, 3), 32'h1);
    chk("os_w1c",      a(0, 3), 32'h0, 4'b0000);
    chk("os_hold",     a(0, 2), 32'd0, 4'b0000);

    // auto-reload, PRESET=2, PRE=2: expiry every 6 cycles
    wr(a(1, 1), 32'd2);
    wr(a(1, 0), 32'h20B);
    chk("ar_f1", a(1, 2), 32'd2, 4'b0000);
    chk("ar_f2", a(1, 2), 32'd2, 4'b0000);
    chk("ar_f3", a(1, 2), 32'd2, 4'b0000);
    chk("ar_f4", a(1, 2), 32'd1, 4'b0000);
    chk("ar_f5", a(1, 2), 32'd1, 4'b0000);
    chk("ar_f6", a(1, 2), 32'd1, 4'b0000);
    chk("ar_f7_reload", a(1, 2), 32'd2, 4'b0010);
    wr(a(1, 3), 32'h1);
    chk("ar_w1c",  a(1, 3), 32'h0, 4'b0000);
    chk("ar_f9",   a(1, 2), 32'd2, 4'b0000);
    chk("ar_f10",  a(1, 2), 32'd1, 4'b0000);
    chk("ar_f11",  a(1, 3), 32'h0, 4'b0000);
    chk("ar_f12",  a(1, 3), 32'h0, 4'b0000);
    chk("ar_f13_pend", a(1, 3), 32'h1, 4'b0010);
    wr(a(1, 0), 32'h0);
    chk("ar_masked_ctrl", a(1, 0), 32'h0, 4'b0000);
    chk("ar_masked_pend", a(1, 3), 32'h1, 4'b0000);
    wr(a(1, 3), 32'h1);

    // free-run wrap with CNT_W=8
    wr(a(0, 1), 32'd1);
    wr(a(0, 0), 32'hD);
    chk("fr_g1",   a(0, 2), 32'h01, 4'b0000);
    chk("fr_g2",   a(0, 2), 32'h00, 4'b0000);
    chk("fr_wrap", a(0, 2), 32'hFF, 4'b0001);
    chk("fr_g4",   a(0, 2), 32'hFE, 4'b0001);
    wr(a(0, 0), 32'h0);
    chk("fr_stop_discard", a(0, 2), 32'hFE, 4'b0000);
    wr(a(0, 3), 32'h1);

    // W1C colliding with expiry: set wins
    wr(a(0, 1), 32'd2);
    wr(a(0, 0), 32'h9);
    chk("ca_h1", a(0, 2), 32'd2, 4'b0000);
    chk("ca_h2", a(0, 2), 32'd1, 4'b0000);
    wr(a(0, 3), 32'h1);
    chk("ca_set_wins", a(0, 3), 32'h1, 4'b0001);
    chk("ca_en_clr",   a(0, 0), 32'h8, 4'b0001);
    wr(a(0, 3), 32'h1);
    chk("ca_cleared",  a(0, 3), 32'h0, 4'b0000);

    // PRESET write colliding with expiry: write wins, no PEND
    wr(a(0, 1), 32'd2);
    wr(a(0, 0), 32'h9);
    chk("cb_j1", a(0, 2), 32'd2, 4'b0000);
    chk("cb_j2", a(0, 2), 32'd1, 4'b0000);
    wr(a(0, 1), 32'd5);
    chk("cb_no_pend", a(0, 3), 32'h0, 4'b0000);
    chk("cb_cnt_new", a(0, 2), 32'd4, 4'b0000);
    wr(a(0, 0), 32'h0);

    // PRESET truncated to CNT_W; COUNT writes ignored
    wr(a(0, 1), 32'h1FF);
    chk("zx_preset", a(0, 1), 32'hFF, 4'b0000);
    wr(a(0, 2), 32'h77);
    chk("ro_count",  a(0, 2), 32'hFF, 4'b0000);

    // isolation: ch2 PRESET=3, ch3 PRESET=4, both auto-reload
    wr(a(2, 1), 32'd3);
    wr(a(3, 1), 32'd4);
    wr(a(2, 0), 32'hB);
    wr(a(3, 0), 32'hB);
    chk("iso_ch2_k3", a(2, 2), 32'd2, 4'b0000);
    chk("iso_ch3_k4", a(3, 2), 32'd3, 4'b0000);
    chk("iso_ch2_irq", a(2, 3), 32'h1, 4'b0100);
    wr(a(3, 2), 32'h55);
    chk("iso_ch3_ro", a(3, 2), 32'd1, 4'b0100);
    chk("iso_ch3_irq", a(3, 3), 32'h1, 4'b1100);
    wr(a(2, 3), 32'h1);
    chk("iso_ch2_setwins", a(2, 3), 32'h1, 4'b1100);
    chk("iso_ch3_k9", a(3, 2), 32'd2, 4'b1100);
    wr(a(2, 0), 32'h0);
    wr(a(3, 0), 32'h0);
    chk("iso_ch2_stop", a(2, 2), 32'd2, 4'b0000);
    chk("iso_ch3_stop", a(3, 2), 32'd1, 4'b0000);

    // asynchronous reset mid-count
    wr(a(1, 1), 32'd4);
    wr(a(1, 0), 32'h9);
    chk("rs_pre", a(1, 2), 32'd4, 4'b0000);
    @(posedge clk_in);
    #2 sys_rstn = 1'b0;
    chk("rs_count", a(1, 2), 32'h0, 4'b0000);
    chk("rs_ctrl",  a(1, 0), 32'h0, 4'b0000);
    chk("rs_preset0", a(0, 1), 32'h0, 4'b0000);
    chk("rs_status2", a(2, 3), 32'h0, 4'b0000);
    @(posedge clk_in);
    #3 sys_rstn = 1'b1;
    repeat (8) @(posedge clk_in);
    #1;
    chk("rs_after_status", a(1, 3), 32'h0, 4'b0000);
    chk("rs_after_count",  a(1, 2), 32'h0, 4'b0000);

    repeat (2) @(negedge clk_in);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
